// File: rtl/phase_sequencer.sv
// Phase sequencer: walks N_PHASES one-hot phases of i_DIV+1 clocks each, in continuous or single-shot mode.
// All outputs are registered (one clock after the deciding edge); i_STALL freezes count/phase in place, no other backpressure.
module phase_sequencer #(
  parameter int N_PHASES = 3,
  parameter int CNT_W    = 4
) (
  input  logic                i_CLOCK,
  input  logic                i_RESET_N,
  input  logic                i_START,
  input  logic                i_STOP,
  input  logic                i_MODE,
  input  logic                i_STALL,
  input  logic [CNT_W-1:0]    i_DIV,
  output logic [N_PHASES-1:0] o_PHASE,
  output logic [2:0]          o_PHASE_IDX,
  output logic                o_STROBE,
  output logic                o_DONE,
  output logic                o_BUSY
);

  typedef enum logic [1:0] {IDLE, RUN, STALL} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [CNT_W-1:0]    div_q, div_d;
  logic [2:0]          phase_q, phase_d;
  logic                stop_q, stop_d;
  logic [N_PHASES-1:0] phase_oh_d;
  logic [2:0]          idx_d;
  logic                strobe_d, done_d, busy_d;

  logic start_ok, boundary, last, wrap, finish;

  assign start_ok = i_START & ~i_STOP;
  assign boundary = (count_q == div_q);
  assign last     = (phase_q == 3'(N_PHASES - 1));
  assign wrap     = (state_q != IDLE) & ~i_STALL & boundary & last;
  // A stop seen on the wrap clock itself still ends this sequence.
  assign finish   = wrap & (i_MODE | stop_q | i_STOP);

  always_ff @(posedge i_CLOCK or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      state_q     <= IDLE;
      count_q     <= '0;
      div_q       <= '0;
      phase_q     <= '0;
      stop_q      <= 1'b0;
      o_PHASE     <= '0;
      o_PHASE_IDX <= '0;
      o_STROBE    <= 1'b0;
      o_DONE      <= 1'b0;
      o_BUSY      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      div_q       <= div_d;
      phase_q     <= phase_d;
      stop_q      <= stop_d;
      o_PHASE     <= phase_oh_d;
      o_PHASE_IDX <= idx_d;
      o_STROBE    <= strobe_d;
      o_DONE      <= done_d;
      o_BUSY      <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (start_ok) state_d = RUN;
      RUN, STALL: begin
        if (i_STALL)     state_d = STALL;
        else if (finish) state_d = IDLE;
        else             state_d = RUN;
      end
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d  = count_q;
    phase_d  = phase_q;
    div_d    = div_q;
    stop_d   = stop_q;
    strobe_d = 1'b0;
    done_d   = 1'b0;
    if (state_q == IDLE) begin
      if (start_ok) begin
        count_d  = '0;
        phase_d  = '0;
        div_d    = i_DIV;
        stop_d   = 1'b0;
        strobe_d = 1'b1;
      end
    end else begin
      stop_d = stop_q | i_STOP;
      if (!i_STALL) begin
        if (!boundary) begin
          count_d = count_q + 1'b1;
        end else begin
          count_d = '0;
          if (!last) begin
            phase_d  = phase_q + 3'd1;
            strobe_d = 1'b1;
          end else begin
            phase_d = '0;
            done_d  = 1'b1;
            stop_d  = 1'b0;
            // Divider is only picked up at the start of a new sequence.
            if (!finish) begin
              div_d    = i_DIV;
              strobe_d = 1'b1;
            end
          end
        end
      end
    end

    busy_d = (state_d != IDLE);
    idx_d  = busy_d ? phase_d : 3'd0;
    for (int i = 0; i < N_PHASES; i++) begin
      phase_oh_d[i] = busy_d && (phase_d == 3'(i));
    end
  end

endmodule

// File: doc/phase_sequencer.md
PHASE_SEQUENCER -- requirements
Module: phase_sequencer

Interface
REQ-001 Parameter N_PHASES, default 3, number of sequencer phases; legal range 2..8.
REQ-002 Parameter CNT_W, default 4, width of the phase-length divider.
REQ-003 i_CLOCK  input  1  single clock; all state changes on its rising edge only; no negedge logic.
REQ-004 i_RESET_N  input  1  reset, asynchronous, active-low.
REQ-005 i_START  input  1  level; starts a sequence when the block is idle.
REQ-006 i_STOP  input  1  level; requests return to idle at the end of the current sequence.
REQ-007 i_MODE  input  1  0 = continuous, 1 = single sequence.
REQ-008 i_STALL  input  1  freezes the sequencer in place.
REQ-009 i_DIV  input  CNT_W  each phase lasts i_DIV+1 clocks.
REQ-010 o_PHASE  output  N_PHASES  one-hot active phase; all zero when idle.
REQ-011 o_PHASE_IDX  output  3  binary index of the active phase.
REQ-012 o_STROBE  output  1  one-clock pulse in the first clock of each phase.
REQ-013 o_DONE  output  1  one-clock pulse after the last phase of a sequence completes.
REQ-014 o_BUSY  output  1  high while in RUN or STALL.

Function
REQ-015 The FSM SHALL have states IDLE, RUN and STALL, and all outputs SHALL be registered.
REQ-016 IDLE -> RUN on a clock with i_START=1 and i_STOP=0; on that edge: phase=0, count=0, div_q=i_DIV, o_STROBE=1.
REQ-017 In IDLE with i_START=1 and i_STOP=1 simultaneously, the block SHALL remain in IDLE (stop wins).
REQ-018 In RUN with i_STALL=0, count SHALL increment each clock; when count==div_q, count SHALL clear and phase SHALL advance by one.
REQ-019 Phase SHALL advance from N_PHASES-1 to 0 (wrap); o_STROBE SHALL be 1 in the first clock of every new phase, else 0.
REQ-020 div_q SHALL be reloaded from i_DIV only at sequence start (IDLE exit and each wrap to phase 0); i_DIV changes mid-sequence SHALL have no effect until then.
REQ-021 i_DIV=0 SHALL give one-clock phases, with o_STROBE high continuously while running.
REQ-022 RUN -> STALL when i_STALL=1; in STALL, count, phase, o_PHASE and o_PHASE_IDX SHALL hold and o_STROBE SHALL be 0; STALL -> RUN when i_STALL=0, resuming from the held count.
REQ-023 A phase boundary coinciding with i_STALL=1 SHALL NOT advance; the advance SHALL occur on the first non-stalled clock.
REQ-024 At wrap from phase N_PHASES-1, o_DONE SHALL pulse for one clock coincident with the new phase-0 o_STROBE (continuous mode) or with o_BUSY falling (IDLE return).
REQ-025 The block SHALL return to IDLE at wrap when i_MODE=1, or when i_STOP was sampled 1 at any clock during that sequence (sticky stop_q, cleared on IDLE entry).
REQ-026 On return to IDLE, o_PHASE SHALL be 0, o_PHASE_IDX 0, o_BUSY 0 and o_STROBE 0.
REQ-027 i_STALL and i_STOP in IDLE SHALL have no effect other than the rule in REQ-017; i_MODE SHALL be sampled at wrap.
REQ-028 count SHALL be CNT_W bits and SHALL never exceed div_q.

Reset
REQ-029 i_RESET_N=0 SHALL immediately, without a clock edge, force IDLE, count=0, phase=0, div_q=0 and stop_q=0, with every output 0.
REQ-030 Reset asserted mid-sequence SHALL abort the sequence; after release, the block SHALL wait for i_START and SHALL NOT resume.
REQ-031 Reset release SHALL take effect on the first rising edge after deassertion.

Verification
REQ-032 N=3, DIV=1, MODE=0, START pulsed: o_PHASE = 001,001,010,010,100,100,001...; o_STROBE on clocks 0,2,4,6; o_DONE on clock 6.
REQ-033 N=3, DIV=0, MODE=1: o_PHASE = 001,010,100 then 000; o_DONE and o_BUSY fall on clock 3; no further activity without START.
REQ-034 DIV=3, STALL high for 5 clocks during phase 1 count 2: phase-1 dwell is 9 clocks, no strobe during the stall, next phase is 2.
REQ-035 STOP pulsed for one clock in phase 0 (continuous, N=4): phases 1,2,3 complete, then IDLE with o_DONE pulse; DIV changed 1->2 mid-sequence applies only after wrap.
REQ-036 i_RESET_N dropped asynchronously mid-phase 2: all outputs 0 before the next edge; START together with STOP after release: stays IDLE.
